// File: rtl/keyvalue_param.sv
// rtl/keyvalue_param.sv - parametrised key/value table slave with sequential scan
module keyvalue_param #(
    parameter int KEY_W  = 8,
    parameter int VAL_W  = 16,
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_1,
    input  logic                     CYC_i,
    input  logic                     STB_i,
    input  logic                     WE_i,
    input  logic                     ADR_IS_KEY_i,
    input  logic                     DAT_IS_KEY_i,
    input  logic [DATA_W-1:0]        ADR_i,
    input  logic [DATA_W-1:0]        DAT_i,
    output logic                     ACK_o,
    output logic [DATA_W-1:0]        DAT_o,
    output logic                     HIT_o,
    output logic                     DUP_o,
    output logic                     ERR_o,
    output logic [$clog2(DEPTH):0]   COUNT_o,
    output logic [31:0]              LA_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, ACK = 2'd2} state_t;
    typedef enum logic [1:0] {OP_INS = 2'd0, OP_DEL = 2'd1, OP_LKP = 2'd2, OP_REV = 2'd3} op_t;

    state_t             state;
    op_t                op;
    logic [KEY_W-1:0]   key_l;
    logic [VAL_W-1:0]   val_l;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   free_idx;
    logic               free_found;
    logic [1:0]         rev_hits;
    logic [KEY_W-1:0]   rev_key;
    logic [DEPTH-1:0]   valid;
    logic [CNT_W-1:0]   count;
    logic [KEY_W-1:0]   keys [DEPTH];
    logic [VAL_W-1:0]   vals [DEPTH];

    logic               key_match;
    logic               val_match;
    logic               is_last;
    logic               ins_room;
    logic [IDX_W-1:0]   ins_slot;
    logic [1:0]         rev_hits_nx;
    logic [KEY_W-1:0]   rev_key_nx;
    logic               done;
    logic               r_hit;
    logic               r_dup;
    logic               r_err;
    logic [DATA_W-1:0]  r_dat;
    logic               set_v;
    logic               clr_v;
    logic               wr_en;
    logic [IDX_W-1:0]   wr_idx;
    logic               unused_bits;

    assign unused_bits = ^{ADR_i, DAT_i};

    // Per-cycle examination of entry idx and the result it would commit
    always_comb begin
        key_match   = valid[idx] && (keys[idx] == key_l);
        val_match   = valid[idx] && (vals[idx] == val_l);
        is_last     = (idx == IDX_W'(DEPTH - 1));
        ins_room    = free_found || !valid[idx];
        ins_slot    = free_found ? free_idx : idx;
        rev_hits_nx = (val_match && rev_hits != 2'd2) ? rev_hits + 2'd1 : rev_hits;
        rev_key_nx  = (val_match && rev_hits == 2'd0) ? keys[idx] : rev_key;
        done  = 1'b0;
        r_hit = 1'b0;
        r_dup = 1'b0;
        r_err = 1'b0;
        r_dat = '0;
        set_v = 1'b0;
        clr_v = 1'b0;
        case (op)
            OP_INS: begin
                if (key_match) begin
                    done  = 1'b1;
                    r_hit = 1'b1;
                    r_dup = 1'b1;
                    r_dat = DATA_W'(val_l);
                end else if (is_last) begin
                    done = 1'b1;
                    if (ins_room) begin
                        set_v = 1'b1;
                        r_dat = DATA_W'(val_l);
                    end else begin
                        r_err = 1'b1;
                    end
                end
            end
            OP_DEL: begin
                if (key_match) begin
                    done  = 1'b1;
                    r_hit = 1'b1;
                    clr_v = 1'b1;
                    r_dat = DATA_W'(vals[idx]);
                end else if (is_last) begin
                    done = 1'b1;
                end
            end
            OP_LKP: begin
                if (key_match) begin
                    done  = 1'b1;
                    r_hit = 1'b1;
                    r_dat = DATA_W'(vals[idx]);
                end else if (is_last) begin
                    done = 1'b1;
                end
            end
            default: begin
                if (is_last) begin
                    done  = 1'b1;
                    r_hit = (rev_hits_nx != 2'd0);
                    r_dup = rev_hits_nx[1];
                    r_dat = DATA_W'(rev_key_nx);
                end
            end
        endcase
        wr_en  = (state == SCAN) && (op == OP_INS) && !sys_rst_1 && (key_match || set_v);
        wr_idx = key_match ? idx : ins_slot;
    end

    // Key/value storage; deliberately unreset, validity lives in valid[]
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            keys[wr_idx] <= key_l;
            vals[wr_idx] <= val_l;
        end
    end

    // Control FSM: latch request, scan one entry per cycle, commit on entry to ACK
    always_ff @(posedge sys_clk) begin
        if (sys_rst_1) begin
            state      <= IDLE;
            op         <= OP_LKP;
            key_l      <= '0;
            val_l      <= '0;
            idx        <= '0;
            free_idx   <= '0;
            free_found <= 1'b0;
            rev_hits   <= '0;
            rev_key    <= '0;
            valid      <= '0;
            count      <= '0;
            ACK_o      <= 1'b0;
            DAT_o      <= '0;
            HIT_o      <= 1'b0;
            DUP_o      <= 1'b0;
            ERR_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ACK_o <= 1'b0;
                    if (CYC_i && STB_i) begin
                        op         <= WE_i ? (ADR_IS_KEY_i ? OP_INS : OP_DEL)
                                           : (DAT_IS_KEY_i ? OP_REV : OP_LKP);
                        key_l      <= ADR_i[KEY_W-1:0];
                        val_l      <= DAT_i[VAL_W-1:0];
                        idx        <= '0;
                        free_found <= 1'b0;
                        rev_hits   <= '0;
                        rev_key    <= '0;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    idx      <= idx + IDX_W'(1);
                    rev_hits <= rev_hits_nx;
                    rev_key  <= rev_key_nx;
                    if (!valid[idx] && !free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                    if (done) begin
                        state <= ACK;
                        ACK_o <= 1'b1;
                        DAT_o <= r_dat;
                        HIT_o <= r_hit;
                        DUP_o <= r_dup;
                        ERR_o <= r_err;
                        if (set_v) begin
                            valid[ins_slot] <= 1'b1;
                            count           <= count + CNT_W'(1);
                        end
                        if (clr_v) begin
                            valid[idx] <= 1'b0;
                            count      <= count - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    ACK_o <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign COUNT_o = count;
    assign LA_o    = {state, HIT_o, DUP_o, ERR_o, 3'b000, 8'(count), 16'(idx)};

endmodule

// File: tb/tb_keyvalue_param.sv
// tb/tb_keyvalue_param.sv - randomized self-checking bench for keyvalue_param
module tb_keyvalue_param;

    localparam int KEY_W  = 8;
    localparam int VAL_W  = 16;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 32;

    localparam int OP_INS = 0;
    localparam int OP_DEL = 1;
    localparam int OP_LKP = 2;
    localparam int OP_REV = 3;

    logic              sys_clk = 1'b0;
    logic              sys_rst_1;
    logic              CYC_i;
    logic              STB_i;
    logic              WE_i;
    logic              ADR_IS_KEY_i;
    logic              DAT_IS_KEY_i;
    logic [DATA_W-1:0] ADR_i;
    logic [DATA_W-1:0] DAT_i;
    logic              ACK_o;
    logic [DATA_W-1:0] DAT_o;
    logic              HIT_o;
    logic              DUP_o;
    logic              ERR_o;
    logic [3:0]        COUNT_o;
    logic [31:0]       LA_o;

    keyvalue_param #(
        .KEY_W (KEY_W),
        .VAL_W (VAL_W),
        .DEPTH (DEPTH),
        .DATA_W(DATA_W)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_1   (sys_rst_1),
        .CYC_i       (CYC_i),
        .STB_i       (STB_i),
        .WE_i        (WE_i),
        .ADR_IS_KEY_i(ADR_IS_KEY_i),
        .DAT_IS_KEY_i(DAT_IS_KEY_i),
        .ADR_i       (ADR_i),
        .DAT_i       (DAT_i),
        .ACK_o       (ACK_o),
        .DAT_o       (DAT_o),
        .HIT_o       (HIT_o),
        .DUP_o       (DUP_o),
        .ERR_o       (ERR_o),
        .COUNT_o     (COUNT_o),
        .LA_o        (LA_o)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    logic        m_valid [DEPTH];
    logic [7:0]  m_key   [DEPTH];
    logic [15:0] m_val   [DEPTH];

    logic [31:0] o_dat;
    logic        o_hit;
    logic        o_dup;
    logic        o_err;
    int          o_lat;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    endtask

    // Table semantics in plain terms: find the key, find the lowest free slot, act.
    task automatic model_op(input int op, input logic [7:0] k, input logic [15:0] v,
                            output logic [31:0] e_dat, output logic e_hit,
                            output logic e_dup, output logic e_err, output int e_lat);
        int found = -1;
        int freei = -1;
        int n = 0;
        e_dat = 32'h0;
        e_hit = 1'b0;
        e_dup = 1'b0;
        e_err = 1'b0;
        e_lat = DEPTH + 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (m_valid[i] && m_key[i] == k && found < 0) found = i;
            if (!m_valid[i] && freei < 0) freei = i;
        end
        case (op)
            OP_INS: begin
                if (found >= 0) begin
                    m_val[found] = v;
                    e_hit = 1'b1;
                    e_dup = 1'b1;
                    e_dat = {16'h0, v};
                    e_lat = found + 2;
                end else if (freei >= 0) begin
                    m_valid[freei] = 1'b1;
                    m_key[freei]   = k;
                    m_val[freei]   = v;
                    e_dat = {16'h0, v};
                end else begin
                    e_err = 1'b1;
                end
            end
            OP_DEL, OP_LKP: begin
                if (found >= 0) begin
                    e_dat = {16'h0, m_val[found]};
                    e_hit = 1'b1;
                    e_lat = found + 2;
                    if (op == OP_DEL) m_valid[found] = 1'b0;
                end
            end
            default: begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (m_valid[i] && m_val[i] == v) begin
                        if (n == 0) e_dat = {24'h0, m_key[i]};
                        n++;
                    end
                end
                e_hit = (n >= 1);
                e_dup = (n >= 2);
            end
        endcase
    endtask

    task automatic drive_req(input int op, input logic [7:0] k, input logic [15:0] v);
        logic [31:0] junk;
        junk         = $urandom();
        WE_i         = (op == OP_INS) || (op == OP_DEL);
        ADR_IS_KEY_i = (op == OP_INS);
        DAT_IS_KEY_i = (op == OP_REV);
        ADR_i        = {junk[31:8], k};
        DAT_i        = {junk[15:0], v};
        CYC_i        = 1'b1;
        STB_i        = 1'b1;
        @(posedge sys_clk);
        #1;
        CYC_i = 1'b0;
        STB_i = 1'b0;
    endtask

    task automatic do_op(input int op, input logic [7:0] k, input logic [15:0] v, input string tag);
        logic [31:0] e_dat;
        logic        e_hit;
        logic        e_dup;
        logic        e_err;
        int          e_lat;
        bit          got;
        model_op(op, k, v, e_dat, e_hit, e_dup, e_err, e_lat);
        drive_req(op, k, v);
        got   = 1'b0;
        o_lat = 0;
        for (int c = 1; c <= 20 && !got; c++) begin
            if (ACK_o) begin
                got   = 1'b1;
                o_lat = c;
            end else begin
                @(posedge sys_clk);
                #1;
            end
        end
        if (!got) begin
            check({tag, "_ack_timeout"}, 32'h0, 32'h1);
            return;
        end
        o_dat = DAT_o;
        o_hit = HIT_o;
        o_dup = DUP_o;
        o_err = ERR_o;
        check({tag, "_lat"}, 32'(o_lat), 32'(e_lat));
        check({tag, "_dat"}, o_dat, e_dat);
        check({tag, "_hit"}, 32'(o_hit), 32'(e_hit));
        check({tag, "_dup"}, 32'(o_dup), 32'(e_dup));
        check({tag, "_err"}, 32'(o_err), 32'(e_err));
        check({tag, "_count"}, 32'(COUNT_o), 32'(model_count()));
        check({tag, "_la_flags"}, 32'(LA_o[29:27]), 32'({e_hit, e_dup, e_err}));
        check({tag, "_la_count"}, 32'(LA_o[23:16]), 32'(model_count()));
        @(posedge sys_clk);
        #1;
        check({tag, "_ack_pulse"}, 32'(ACK_o), 32'h0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"}, 32'(ACK_o), 32'h0);
        check({tag, "_dat"}, DAT_o, 32'h0);
        check({tag, "_flags"}, 32'({HIT_o, DUP_o, ERR_o}), 32'h0);
        check({tag, "_count"}, 32'(COUNT_o), 32'h0);
        check({tag, "_la"}, LA_o, 32'h0);
    endtask

    initial begin
        int acks;
        int op;
        logic [7:0]  rk;
        logic [15:0] rv;

        sys_rst_1    = 1'b1;
        CYC_i        = 1'b0;
        STB_i        = 1'b0;
        WE_i         = 1'b0;
        ADR_IS_KEY_i = 1'b0;
        DAT_IS_KEY_i = 1'b0;
        ADR_i        = '0;
        DAT_i        = '0;
        model_clear();
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_1 = 1'b0;
        check_reset_outputs("rst");

        // insert into empty table, then look it up
        do_op(OP_INS, 8'h12, 16'hBEEF, "ins1");
        check("ins1_lat9", 32'(o_lat), 32'd9);
        check("ins1_cnt1", 32'(COUNT_o), 32'd1);
        do_op(OP_LKP, 8'h12, 16'h0, "lkp1");
        check("lkp1_beef", o_dat, 32'h0000BEEF);
        check("lkp1_lat2", 32'(o_lat), 32'd2);

        // overwrite an existing key
        do_op(OP_INS, 8'h12, 16'h1234, "ins2");
        check("ins2_dup", 32'(o_dup), 32'h1);
        do_op(OP_LKP, 8'h12, 16'h0, "lkp2");
        check("lkp2_val", o_dat, 32'h00001234);

        // fill the table and overflow it
        for (int i = 0; i < 7; i++) do_op(OP_INS, 8'(8'h20 + i), 16'(16'h1000 + i), "fill");
        do_op(OP_INS, 8'h30, 16'h5555, "full");
        check("full_err", 32'(o_err), 32'h1);
        check("full_cnt8", 32'(COUNT_o), 32'd8);
        do_op(OP_LKP, 8'h30, 16'h0, "full_lkp");
        check("full_lkp_miss", 32'(o_hit), 32'h0);

        // delete slot 3 and refill it
        do_op(OP_DEL, 8'h22, 16'h0, "del3");
        check("del3_cnt7", 32'(COUNT_o), 32'd7);
        do_op(OP_INS, 8'h40, 16'h7777, "reins");
        do_op(OP_REV, 8'h00, 16'h7777, "rev_slot3");
        check("rev_slot3_key", o_dat, 32'h00000040);

        // reset in the third scan cycle of an insert aborts it
        drive_req(OP_INS, 8'h66, 16'h4242);
        @(posedge sys_clk);
        #1;
        @(posedge sys_clk);
        #1;
        sys_rst_1 = 1'b1;
        @(posedge sys_clk);
        #1;
        sys_rst_1 = 1'b0;
        model_clear();
        check_reset_outputs("abort");
        acks = 0;
        repeat (12) begin
            @(posedge sys_clk);
            #1;
            if (ACK_o) acks++;
        end
        check("abort_noack", 32'(acks), 32'h0);
        do_op(OP_LKP, 8'h66, 16'h0, "abort_lkp");
        check("abort_lkp_lat9", 32'(o_lat), 32'd9);

        // duplicate value in slots 1 and 4, reverse lookup
        do_op(OP_INS, 8'h50, 16'h0001, "aa0");
        do_op(OP_INS, 8'h05, 16'h00AA, "aa1");
        do_op(OP_INS, 8'h51, 16'h0002, "aa2");
        do_op(OP_INS, 8'h52, 16'h0003, "aa3");
        do_op(OP_INS, 8'h09, 16'h00AA, "aa4");
        do_op(OP_REV, 8'h00, 16'h00AA, "rev_aa");
        check("rev_aa_key", o_dat, 32'h00000005);
        check("rev_aa_dup", 32'(o_dup), 32'h1);
        check("rev_aa_lat9", 32'(o_lat), 32'd9);

        // random mix over a small key/value space to force hits, fills and duplicates
        for (int n = 0; n < 300; n++) begin
            op = int'($urandom_range(0, 3));
            rk = 8'($urandom_range(0, 11));
            rv = 16'($urandom_range(0, 3) * 16'h1111);
            do_op(op, rk, rv, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keyvalue_param.md
# keyvalue_param

Parametrised successor to the fixed-width key-value cores: a Wishbone-classic slave holding `DEPTH` key/value pairs of configurable width. Beyond insert and lookup, it adds delete, reverse lookup (value to key), occupancy count, full and miss reporting, and a debug word. It sits behind the user-project wrapper on the Wishbone bus or on a GPIO-driven port, one instance per channel. Lookups use a sequential one-entry-per-cycle scan, so area stays flat in `DEPTH`.

## Interface
- `KEY_W`, 8: key width in bits; 1..`DATA_W`.
- `VAL_W`, 16: value width in bits; 1..`DATA_W`.
- `DEPTH`, 8: number of entries; power of two, at least 2.
- `DATA_W`, 32: bus width of `DAT_i`, `ADR_i` and `DAT_o`.
- `sys_clk` in 1: single clock; all logic is rising-edge.
- `sys_rst_1` in 1: reset, synchronous, active-high.
- `CYC_i` in 1: bus cycle.
- `STB_i` in 1: strobe; a request is `CYC_i & STB_i`.
- `WE_i` in 1: 1 selects write-class operations, 0 selects read-class.
- `ADR_IS_KEY_i` in 1: when `WE_i`=1, selects insert (1) or delete (0).
- `DAT_IS_KEY_i` in 1: when `WE_i`=0, selects lookup (0) or reverse lookup (1).
- `ADR_i` in `DATA_W`: key on bits `[KEY_W-1:0]`; upper bits ignored.
- `DAT_i` in `DATA_W`: value on bits `[VAL_W-1:0]`; upper bits ignored.
- `ACK_o` out 1: one-cycle completion pulse.
- `DAT_o` out `DATA_W`: result, zero-extended.
- `HIT_o` out 1: the key or value was found.
- `DUP_o` out 1: insert updated an existing key, or reverse lookup matched 2 or more entries.
- `ERR_o` out 1: insert refused because the table is full.
- `COUNT_o` out `clog2(DEPTH)+1`: number of valid entries.
- `LA_o` out 32: debug word, `{state[1:0], HIT, DUP, ERR, 3'b0, COUNT zero-extended to 8, scan index zero-extended to 16}`.

## Operation
- Storage: per entry, a `valid` flop plus `KEY_W`+`VAL_W` data bits. Only the `valid` flops are reset.
- FSM states are IDLE, SCAN and ACK.
  - IDLE to SCAN on a request. The opcode, key (`ADR_i`) and value (`DAT_i`) are latched, and the index is cleared to 0.
  - In SCAN, the block examines entry `idx` each cycle and increments `idx`.
  - SCAN to ACK on an early stop, or after entry `DEPTH`-1 has been examined.
  - ACK to IDLE unconditionally. `ACK_o` is high only in ACK.
- Insert (`WE_i`=1, `ADR_IS_KEY_i`=1):
  - The scan records the lowest-index free slot.
  - On a valid key match, the block stops early, overwrites the value, and sets `HIT`=1, `DUP`=1.
  - With no match after the full scan, it writes to the lowest free slot, sets `valid`, and increments the count (`HIT`=0, `DUP`=0).
  - With no match and no free slot, it writes nothing and sets `ERR`=1.
  - `DAT_o` returns the value written, or 0 on error.
- Delete (`WE_i`=1, `ADR_IS_KEY_i`=0):
  - On a match, it stops early, clears `valid`, decrements the count, and sets `HIT`=1.
  - On a miss, `HIT`=0 and nothing changes.
  - `DAT_o` returns the deleted value, or 0.
- Lookup (`WE_i`=0, `DAT_IS_KEY_i`=0): stops early on a match with `HIT`=1 and `DAT_o` = value. A miss gives `HIT`=0 and `DAT_o`=0.
- Reverse lookup (`WE_i`=0, `DAT_IS_KEY_i`=1):
  - Always runs the full scan, with no early stop.
  - `DAT_o` = key of the lowest-index valid entry whose value equals `DAT_i[VAL_W-1:0]`.
  - `HIT` = at least one match; `DUP` = at least 2 matches.
- Keys are unique by construction, so an insert never creates a second entry for the same key. Key 0 and value 0 are legal.
- All table and count updates happen on the edge that enters ACK.
- `DAT_o`, `HIT_o`, `DUP_o` and `ERR_o` are registered. They are loaded on entry to ACK and held until the next ACK.
- Requests arriving in SCAN or ACK are ignored, never queued. The master must drop `STB_i` the cycle after it samples `ACK_o`.

## Timing
- Request sampled at edge t. Entry i is examined in cycle t+1+i.
- An early stop at entry i gives `ACK_o` high in cycle t+2+i.
- A full scan gives `ACK_o` high in cycle t+1+`DEPTH`.
- Minimum latency is 2 cycles; maximum is `DEPTH`+1.
- Back-to-back: the next request can be sampled in the cycle after ACK, in IDLE.
- `COUNT_o` updates in the same cycle `ACK_o` rises.
- Reset: state goes to IDLE, all `valid` bits and the count go to 0, and `ACK_o`, `DAT_o`, `HIT_o`, `DUP_o`, `ERR_o` go to 0. Outputs are valid the cycle after reset is sampled.
- Reset during SCAN or ACK aborts the operation. No further ACK is issued and no partial write is kept.
- Reset has priority over a request in the same cycle.

## Test plan
All cases use `KEY_W`=8, `VAL_W`=16, `DEPTH`=8.
- Insert key 0x12 with value 0xBEEF into an empty table: `ACK_o` 9 cycles after the request, `HIT_o`=0, `COUNT_o`=1. A following lookup of 0x12 then acks in 2 cycles with `DAT_o`=0x0000BEEF and `HIT_o`=1.
- Insert 0x12 again with value 0x1234: acks in 2 cycles with `DUP_o`=1 and `COUNT_o` still 1. A lookup then returns 0x1234.
- Fill 8 distinct keys, then insert a 9th key: `ERR_o`=1, `COUNT_o`=8, and a lookup of the 9th key misses.
- Delete the key stored in slot 3: `HIT_o`=1 and `COUNT_o`=7. A new insert lands in slot 3, checked by a reverse lookup returning the new key.
- Store value 0x00AA under keys 0x05 and 0x09 in slots 1 and 4, then reverse-lookup 0x00AA: acks in 9 cycles with `DAT_o`=0x05, `HIT_o`=1, `DUP_o`=1.
- Assert reset in the 3rd scan cycle of an insert: no `ACK_o`, all outputs 0. A subsequent lookup of any key gives `HIT_o`=0 after 9 cycles.
